// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO addresses and STATUS bit layout.
package dmem_responder_pkg;

  localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] CYCLES_ADDR = 32'hFFFF_0008;

  localparam int EMPTY_BIT = 0;
  localparam int FULL_BIT  = 1;
  localparam int OVF_BIT   = 2;
  localparam int COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is only taken
// when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH_P-1:0]         data,
  input  logic                       pop,
  output logic [WIDTH_P-1:0]         head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH_P):0]   count
);

  localparam int PTR_W = $clog2(DEPTH_P);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH_P-1:0] storage [DEPTH_P];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH_P));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = storage[rd_ptr];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage arrays are not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus TX FIFO, STATUS and
// cycle-counter MMIO registers, with combinational read data.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int    DATA_WIDTH_P      = 32,
  parameter int    DATA_ADDR_WIDTH_P = 32,
  parameter int    MEM_DEPTH_P       = 256,
  parameter int    FIFO_DEPTH_P      = 8,
  parameter string MEM_INIT_P        = ""
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_mem_wr_en,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_mem_addr,
  input  logic [DATA_WIDTH_P-1:0]      i_mem_wr_data,
  output logic [DATA_WIDTH_P-1:0]      o_mem_rd_data,
  output logic                         o_tx_valid,
  output logic [7:0]                   o_tx_data,
  input  logic                         i_tx_ready,
  output logic                         o_bus_error
);

  localparam int MEM_AW  = $clog2(MEM_DEPTH_P);
  localparam int FIFO_CW = $clog2(FIFO_DEPTH_P) + 1;

  logic [DATA_WIDTH_P-1:0] mem [MEM_DEPTH_P];
  logic [DATA_WIDTH_P-1:0] cycles;
  logic [DATA_WIDTH_P-1:0] status_word;
  logic                    overflow;

  logic               aligned;
  logic               sel_ram;
  logic               sel_tx;
  logic               sel_status;
  logic               sel_cycles;
  logic               mapped;
  logic [MEM_AW-1:0]  word_idx;

  logic               tx_push;
  logic               tx_pop;
  logic               tx_empty;
  logic               tx_full;
  logic [FIFO_CW-1:0] tx_count;

  // Address decode; MMIO addresses are word aligned so an exact match implies alignment.
  assign aligned    = (i_mem_addr[1:0] == 2'b00);
  assign sel_ram    = aligned && ((i_mem_addr >> (MEM_AW + 2)) == '0);
  assign sel_tx     = (i_mem_addr == DATA_ADDR_WIDTH_P'(TXDATA_ADDR));
  assign sel_status = (i_mem_addr == DATA_ADDR_WIDTH_P'(STATUS_ADDR));
  assign sel_cycles = (i_mem_addr == DATA_ADDR_WIDTH_P'(CYCLES_ADDR));
  assign mapped     = sel_ram || sel_tx || sel_status || sel_cycles;
  assign word_idx   = i_mem_addr[MEM_AW+1:2];

  assign tx_push    = i_mem_wr_en && sel_tx;
  assign tx_pop     = o_tx_valid && i_tx_ready;
  assign o_tx_valid = !tx_empty;

  sync_fifo #(
    .WIDTH_P (8),
    .DEPTH_P (FIFO_DEPTH_P)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .data  (i_mem_wr_data[7:0]),
    .pop   (tx_pop),
    .head  (o_tx_data),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count)
  );

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    status_word                         = '0;
    status_word[COUNT_LSB +: FIFO_CW]   = tx_count;
    status_word[OVF_BIT]                = overflow;
    status_word[FULL_BIT]               = tx_full;
    status_word[EMPTY_BIT]              = tx_empty;
  end

  // Reads are speculative: anything unmapped or misaligned simply returns zero.
  always_comb begin
    o_mem_rd_data = '0;
    if (sel_ram)         o_mem_rd_data = mem[word_idx];
    else if (sel_status) o_mem_rd_data = status_word;
    else if (sel_cycles) o_mem_rd_data = cycles;
  end

  always_ff @(posedge clk) begin
    if (i_mem_wr_en && sel_ram) mem[word_idx] <= i_mem_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles      <= '0;
      overflow    <= 1'b0;
      o_bus_error <= 1'b0;
    end else begin
      if (i_mem_wr_en && sel_cycles) cycles <= i_mem_wr_data;
      else                           cycles <= cycles + 1'b1;

      if (tx_push && tx_full && !tx_pop)
        overflow <= 1'b1;
      else if (i_mem_wr_en && sel_status && i_mem_wr_data[OVF_BIT])
        overflow <= 1'b0;

      if (i_mem_wr_en && !mapped) o_bus_error <= 1'b1;
    end
  end

endmodule
